// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: arbitrates via BREQ/ENIN/ENOUT, then times NADS/NRDS/NWDS.
// Optional NHOLD timeout is compiled in with `define SCMP_BUS_TIMEOUT_EN.
module scmp_bus_ctl #(
  parameter int ADS_CYC = 1,
  parameter int STB_CYC = 2,
  parameter int REC_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mc_ads_n,
  input  logic        mc_rd_n,
  input  logic        mc_wr_n,
  output logic        mc_stall,
  input  logic [15:0] addr_in,
  input  logic [7:0]  dout_in,
  output logic [7:0]  din_out,
  output logic        din_valid,
  output logic        cyc_err,
  output logic [15:0] bus_addr,
  input  logic [7:0]  bus_d_in,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  output logic        bus_ADS_n,
  output logic        bus_RD_n,
  output logic        bus_WR_n,
  input  logic        bus_hold_n,
  output logic        bus_breq,
  input  logic        bus_enin,
  output logic        bus_enout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_ADDR = 3'd2,
    S_STB  = 3'd3,
    S_REC  = 3'd4
  } state_t;

  localparam logic [2:0] ADS_LAST = 3'(ADS_CYC - 1);
  localparam logic [2:0] STB_LAST = 3'(STB_CYC - 1);
  localparam logic [2:0] REC_LAST = 3'(REC_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dir_vld_q, dir_vld_d;
  logic        dir_rd_q, dir_rd_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_d_out_q, bus_d_out_d;
  logic [7:0]  din_out_q, din_out_d;
  logic        din_valid_q, din_valid_d;
  logic        cyc_err_q, cyc_err_d;
  logic        ads_n_q, ads_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        breq_q, breq_d;
  logic        oe_q, oe_d;

  logic        dir_take;
  logic        dir_now;
  logic        rd_now;
  logic        stb_exit;
  logic        tmo_hit;

  // Direction is captured once per cycle, in ARB or ADDR; read wins over write.
  assign dir_take = ((state_q == S_ARB) || (state_q == S_ADDR)) && !dir_vld_q &&
                    (!mc_rd_n || !mc_wr_n);
  assign dir_now  = dir_vld_q || dir_take;
  assign rd_now   = dir_take ? !mc_rd_n : dir_rd_q;
  assign stb_exit = ((cnt_q >= STB_LAST) && bus_hold_n) || tmo_hit;

`ifdef SCMP_BUS_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  assign tmo_hit = (state_q == S_STB) && (wait_q == 8'hFF);

  always_comb begin
    wait_d = wait_q;
    if ((state_d == S_STB) && (state_q != S_STB)) begin
      wait_d = 8'd0;
    end else if ((state_q == S_STB) && !bus_hold_n && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      dir_vld_q   <= 1'b0;
      dir_rd_q    <= 1'b0;
      bus_addr_q  <= 16'd0;
      bus_d_out_q <= 8'd0;
      din_out_q   <= 8'd0;
      din_valid_q <= 1'b0;
      cyc_err_q   <= 1'b0;
      ads_n_q     <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      breq_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_vld_q   <= dir_vld_d;
      dir_rd_q    <= dir_rd_d;
      bus_addr_q  <= bus_addr_d;
      bus_d_out_q <= bus_d_out_d;
      din_out_q   <= din_out_d;
      din_valid_q <= din_valid_d;
      cyc_err_q   <= cyc_err_d;
      ads_n_q     <= ads_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      breq_q      <= breq_d;
      oe_q        <= oe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!mc_ads_n) state_d = S_ARB;
      S_ARB:  if (bus_enin) state_d = S_ADDR;
      S_ADDR: if (cnt_q >= ADS_LAST) state_d = dir_now ? S_STB : S_REC;
      S_STB:  if (stb_exit) state_d = S_REC;
      S_REC:  if (cnt_q >= REC_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; strobes are registered from the next state so they are glitch-free.
  always_comb begin
    cnt_d       = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
    dir_vld_d   = dir_vld_q;
    dir_rd_d    = dir_rd_q;
    bus_addr_d  = bus_addr_q;
    bus_d_out_d = bus_d_out_q;
    din_out_d   = din_out_q;
    din_valid_d = 1'b0;
    cyc_err_d   = 1'b0;

    if (state_d != state_q) cnt_d = 3'd0;

    if ((state_q == S_IDLE) && !mc_ads_n) begin
      bus_addr_d = addr_in;
      dir_vld_d  = 1'b0;
    end

    if (dir_take) begin
      dir_vld_d   = 1'b1;
      dir_rd_d    = !mc_rd_n;
      bus_d_out_d = dout_in;
    end

    if ((state_q == S_STB) && (state_d == S_REC)) begin
      if (rd_now) begin
        din_out_d   = tmo_hit ? 8'hFF : bus_d_in;
        din_valid_d = 1'b1;
      end
      cyc_err_d = tmo_hit;
    end

    if ((state_q == S_ADDR) && (state_d == S_REC)) cyc_err_d = 1'b1;

    ads_n_d = (state_d != S_ADDR);
    rd_n_d  = !((state_d == S_STB) && rd_now);
    wr_n_d  = !((state_d == S_STB) && !rd_now);
    breq_d  = (state_d == S_ARB) || (state_d == S_ADDR) || (state_d == S_STB);
    // Data bus stays driven one extra cycle after NWDS rises, for hold time.
    oe_d    = !rd_now && ((state_d == S_STB) ||
                          ((state_q == S_STB) && (state_d == S_REC)));
  end

  assign mc_stall  = (state_q == S_ARB) || (state_q == S_ADDR) || (state_q == S_STB);
  assign din_out   = din_out_q;
  assign din_valid = din_valid_q;
  assign cyc_err   = cyc_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_d_out = bus_d_out_q;
  assign bus_d_oe  = oe_q;
  assign bus_ADS_n = ads_n_q;
  assign bus_RD_n  = rd_n_q;
  assign bus_WR_n  = wr_n_q;
  assign bus_breq  = breq_q;
  assign bus_enout = bus_enin & ~breq_q;

endmodule
